// File: rtl/ieee_sp_fp_adder_if.sv
// Operand/result bundle for the binary32 adder.
// The tb side drives operands through master; the adder side sits on slave.
interface ieee_sp_fp_adder_if;
    localparam int unsigned WIDTH = 32;

    logic             in_valid;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             out_valid;
    logic [WIDTH-1:0] sum_out;
    logic             underflow_flag;
    logic             overflow_flag;

    modport master (
        output in_valid, a_in, b_in,
        input  out_valid, sum_out, underflow_flag, overflow_flag
    );

    modport slave (
        input  in_valid, a_in, b_in,
        output out_valid, sum_out, underflow_flag, overflow_flag
    );
endinterface

// File: rtl/ieee_sp_fp_adder.sv
// Single-cycle IEEE-754 binary32 adder with registered sum and flags; denormals flush to zero.
// Build option FP_ADD_RNE_EN: round-to-nearest-even when defined, truncation when undefined.
module ieee_sp_fp_adder (
    input  logic                 clk,
    input  logic                 rst_n,
    ieee_sp_fp_adder_if.slave    bus
);
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned EXP      = 8;
    localparam int unsigned MANTISSA = 23;
    localparam int unsigned SIG      = MANTISSA + 1;   // significand with hidden bit
    localparam int unsigned EXT      = SIG + 3;        // plus guard/round/sticky
    localparam int unsigned WIDE     = SIG + 26;       // alignment shifter width
    localparam int unsigned EW       = EXP + 2;        // signed working exponent

    localparam logic [WIDTH-1:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic                sign;
        logic [EXP-1:0]      exp;
        logic [MANTISSA-1:0] frac;
    } fp_t;

    fp_t                 a, b;
    logic                a_nan, b_nan, a_inf, b_inf;
    logic [SIG-1:0]      a_sig, b_sig, big_sig, sml_sig;
    logic [EXP-1:0]      big_exp, exp_diff;
    logic                big_sign, a_big;
    logic [WIDE-1:0]     wide;
    logic [EXT-1:0]      big_ext, sml_ext, dsub, mant;
    logic [EXT:0]        sum_raw;
    logic [4:0]          lzc;
    logic                carry, inc;
    logic signed [EW-1:0] exp_n, exp_r;
    logic [SIG:0]        rnd;
    logic [MANTISSA-1:0] frac_r;
    logic [WIDTH-1:0]    res_c;
    logic                uf_c, of_c;

    logic [WIDTH-1:0]    sum_d, sum_q;
    logic                uf_d, uf_q, of_d, of_q, vld_d, vld_q;

    // Unpack, align, add/subtract, normalize, round, pack.
    always_comb begin
        a        = bus.a_in;
        b        = bus.b_in;
        a_nan    = (a.exp == '1) && (a.frac != '0);
        b_nan    = (b.exp == '1) && (b.frac != '0);
        a_inf    = (a.exp == '1) && (a.frac == '0);
        b_inf    = (b.exp == '1) && (b.frac == '0);
        a_sig    = (a.exp == '0) ? '0 : {1'b1, a.frac};
        b_sig    = (b.exp == '0) ? '0 : {1'b1, b.frac};
        a_big    = (a.exp > b.exp) || ((a.exp == b.exp) && (a_sig >= b_sig));
        big_sign = a_big ? a.sign : b.sign;
        big_exp  = a_big ? a.exp  : b.exp;
        big_sig  = a_big ? a_sig  : b_sig;
        sml_sig  = a_big ? b_sig  : a_sig;
        exp_diff = big_exp - (a_big ? b.exp : a.exp);
        wide     = '0;
        sml_ext  = '0;
        big_ext  = {big_sig, 3'b000};
        sum_raw  = '0;
        dsub     = '0;
        mant     = '0;
        lzc      = '0;
        carry    = 1'b0;
        inc      = 1'b0;
        exp_n    = '0;
        exp_r    = '0;
        rnd      = '0;
        frac_r   = '0;
        res_c    = '0;
        uf_c     = 1'b0;
        of_c     = 1'b0;

        // Beyond 25 positions the smaller operand only survives as sticky.
        if (exp_diff >= 8'd26) begin
            sml_ext = {{(EXT-1){1'b0}}, |sml_sig};
        end else begin
            wide    = {sml_sig, 26'b0} >> exp_diff;
            sml_ext = {wide[WIDE-1:WIDE-26], |wide[WIDE-27:0]};
        end

        if (a.sign == b.sign) begin
            sum_raw = {1'b0, big_ext} + {1'b0, sml_ext};
            carry   = sum_raw[EXT];
            mant    = carry ? {sum_raw[EXT:2], sum_raw[1] | sum_raw[0]} : sum_raw[EXT-1:0];
        end else begin
            dsub = big_ext - sml_ext;
            for (int i = 0; i < EXT; i++) begin
                if (dsub[i]) lzc = 5'(EXT - 1 - i);
            end
            mant = dsub << lzc;
        end
        exp_n = EW'(big_exp) + EW'(carry) - EW'(lzc);

`ifdef FP_ADD_RNE_EN
        inc = mant[2] & (mant[1] | mant[0] | mant[3]);
`else
        inc = 1'b0;
`endif
        rnd = {1'b0, mant[EXT-1:3]} + (SIG+1)'(inc);
        if (rnd[SIG]) begin
            exp_r  = exp_n + EW'(1);
            frac_r = rnd[SIG-1:1];
        end else begin
            exp_r  = exp_n;
            frac_r = rnd[MANTISSA-1:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a.sign != b.sign))) begin
            res_c = QNAN;
        end else if (a_inf) begin
            res_c = {a.sign, 8'hFF, 23'b0};
        end else if (b_inf) begin
            res_c = {b.sign, 8'hFF, 23'b0};
        end else if (mant == '0) begin
            res_c = {a.sign & b.sign, 31'b0};
        end else if (exp_r >= EW'(255)) begin
            res_c = {big_sign, 8'hFF, 23'b0};
            of_c  = 1'b1;
        end else if (exp_r <= EW'(0)) begin
            res_c = {big_sign, 31'b0};
            uf_c  = 1'b1;
        end else begin
            res_c = {big_sign, exp_r[EXP-1:0], frac_r};
        end
    end

    // Output registers load only on valid operands.
    always_comb begin
        vld_d = bus.in_valid;
        sum_d = sum_q;
        uf_d  = uf_q;
        of_d  = of_q;
        if (bus.in_valid) begin
            sum_d = res_c;
            uf_d  = uf_c;
            of_d  = of_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            uf_q  <= 1'b0;
            of_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            uf_q  <= uf_d;
            of_q  <= of_d;
            vld_q <= vld_d;
        end
    end

    assign bus.sum_out        = sum_q;
    assign bus.underflow_flag = uf_q;
    assign bus.overflow_flag  = of_q;
    assign bus.out_valid      = vld_q;
endmodule

// File: tb/tb_ieee_sp_fp_adder.sv
// Directed scoreboard bench for ieee_sp_fp_adder; expectations follow FP_ADD_RNE_EN when defined.
module tb_ieee_sp_fp_adder;
    typedef struct {
        logic [31:0] sum;
        logic        uf;
        logic        of;
        string       tag;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    ieee_sp_fp_adder_if bus ();

    ieee_sp_fp_adder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one operation, push its expectation, then pop and compare after the edge.
    task automatic apply(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input logic uf, input logic of);
        exp_t e;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_in     = a;
        bus.b_in     = b;
        e.sum = s; e.uf = uf; e.of = of; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_queue"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_sum"}, bus.sum_out, e.sum);
                chk({e.tag, "_uf"}, 32'(bus.underflow_flag), 32'(e.uf));
                chk({e.tag, "_of"}, 32'(bus.overflow_flag), 32'(e.of));
            end
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] s, input logic uf,
                            input logic of, input logic v);
        chk({tag, "_sum"}, bus.sum_out, s);
        chk({tag, "_uf"}, 32'(bus.underflow_flag), 32'(uf));
        chk({tag, "_of"}, 32'(bus.overflow_flag), 32'(of));
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    endtask

    logic [31:0] rnd_exp;

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a_in     = '0;
        bus.b_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("pre_rst", 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);

        // Reset asserted while an operation is being presented.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a_in     = 32'h7F7F_FFFF;
        bus.b_in     = 32'h7F7F_FFFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk_outs("mid_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_outs("in_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("post_rst", 32'h0, 1'b0, 1'b0, 1'b0);

        apply("same_a_big", 32'hABE0_0000, 32'hAAE0_0000, 32'hAC0C_0000, 1'b0, 1'b0);

        // Hold: inputs change with in_valid low.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a_in = $urandom;
            bus.b_in = $urandom;
            @(posedge clk);
            #1;
            chk_outs("hold", 32'hAC0C_0000, 1'b0, 1'b0, 1'b0);
        end

        apply("same_b_big",  32'hAA60_0000, 32'hABE0_0000, 32'hABFC_0000, 1'b0, 1'b0);
        apply("mixed_neg",   32'h2A60_0000, 32'hABE0_0000, 32'hABC4_0000, 1'b0, 1'b0);
        apply("one_one",     32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0, 1'b0);
        apply("cancel",      32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b0, 1'b0);
        apply("neg_zeros",   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        apply("three_m1",    32'h4040_0000, 32'hBF80_0000, 32'h4000_0000, 1'b0, 1'b0);
        apply("overflow",    32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 1'b0, 1'b1);
        apply("flags_clear", 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 1'b0, 1'b0);
        apply("underflow",   32'h0080_0001, 32'h8080_0000, 32'h0000_0000, 1'b1, 1'b0);
        apply("denorm_flush",32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
`ifdef FP_ADD_RNE_EN
        rnd_exp = 32'h3F80_0001;
`else
        rnd_exp = 32'h3F80_0000;
`endif
        apply("round_up",    32'h3F80_0000, 32'h33C0_0000, rnd_exp, 1'b0, 1'b0);
        apply("round_tie",   32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b0, 1'b0);
        apply("sticky_only", 32'h3F80_0000, 32'h3280_0000, 32'h3F80_0000, 1'b0, 1'b0);
        apply("inf_minf",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 1'b0, 1'b0);
        apply("nan_in",      32'h3F80_0000, 32'h7F80_0001, 32'h7FC0_0000, 1'b0, 1'b0);
        apply("inf_plus",    32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000, 1'b0, 1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
